commit_trace_buf: RTL and testbench
===================================

COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 Parameter DATA_W, default 32, width of register and memory data fields.
REQ-002 Parameter ADDR_W, default 9, width of memory address field.
REQ-003 Parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 reg_write_sig  input  1  writeback strobe.
REQ-008 reg_num  input  5  writeback destination register.
REQ-009 reg_data  input  DATA_W  writeback data.
REQ-010 wr  input  1  data-memory store strobe.
REQ-011 rd  input  1  data-memory load strobe.
REQ-012 addr  input  ADDR_W  data-memory address.
REQ-013 wr_data  input  DATA_W  store data.
REQ-014 rd_data  input  DATA_W  load data.
REQ-015 trace_ready  input  1  consumer accepts head entry.
REQ-016 overflow_clr  input  1  clears overflow flag and drop counter.
REQ-017 trace_valid  output  1  head entry present.
REQ-018 trace_flags  output  3  {reg_we, mem_wr, mem_rd} of head.
REQ-019 trace_reg_num  output  5  head reg_num.
REQ-020 trace_reg_data  output  DATA_W  head reg_data.
REQ-021 trace_addr  output  ADDR_W  head addr.
REQ-022 trace_mem_data  output  DATA_W  head memory data.
REQ-023 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-024 overflow  output  1  sticky: at least one event dropped.
REQ-025 drop_cnt  output  16  dropped events, saturating at 16'hFFFF.

Function
REQ-026 Event each cycle = (reg_write_sig && reg_num!=0) || wr || rd; one event yields exactly one entry.
REQ-027 Entry fields: reg_we = reg_write_sig && reg_num!=0; mem_wr = wr; mem_rd = rd; reg_num; reg_data; addr; mem_data = wr ? wr_data : rd_data.
REQ-028 Circular FIFO; write/read pointers wrap DEPTH-1 -> 0; full when count==DEPTH, empty when count==0.
REQ-029 First-word-fall-through: entry pushed in cycle N shall appear on trace_* with trace_valid=1 in cycle N+1 when FIFO was empty.
REQ-030 Pop occurs when trace_valid && trace_ready; trace_ready with trace_valid=0 has no effect.
REQ-031 trace_flags/reg_num/reg_data/addr/mem_data shall be driven 0 whenever trace_valid=0.
REQ-032 Push and pop same cycle: count unchanged, both pointers advance; applies also when full.
REQ-033 Event while full without pop: entry dropped, FIFO unchanged, overflow set, drop_cnt increments (saturating).
REQ-034 overflow_clr: overflow<=0, drop_cnt<=0 next edge; a simultaneous drop wins: overflow<=1, drop_cnt<=1.
REQ-035 Head entry and trace_* stable while trace_valid=1 and trace_ready=0.

Reset
REQ-036 reset=0 at edge: pointers 0, count 0, trace_valid 0, overflow 0, drop_cnt 0, timestamp 0; storage contents not reset.
REQ-037 Reset mid-operation discards all entries; events during reset cycle are not captured.
REQ-038 First capture possible in the first cycle with reset=1.

Configuration
REQ-039 Macro COMMIT_TRACE_TS_EN defined: 32-bit free-running cycle counter (wraps FFFFFFFF->0), stored per entry at push, output trace_ts (32, 0 when trace_valid=0).
REQ-040 Macro undefined: no counter, no per-entry timestamp storage, no trace_ts port; all other behaviour identical.

Verification
REQ-041 Reset release; reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF one cycle -> next cycle trace_valid=1, flags=3'b100, reg_num=5, reg_data=DEADBEEF, count=1.
REQ-042 reg_write_sig=1, reg_num=0, wr=rd=0 -> no entry, count stays 0.
REQ-043 wr=1, addr=9'h1A4, wr_data=32'h12345678 plus reg_write_sig reg_num=3 same cycle -> single entry flags=3'b110, mem_data=12345678.
REQ-044 trace_ready=0, 20 consecutive rd events, DEPTH=16 -> count=16, overflow=1, drop_cnt=4; then drain 16 -> entries in order, wrap correct, trace_valid=0.
REQ-045 Full FIFO, event with trace_ready=1 -> count=16, drop_cnt unchanged; overflow_clr with simultaneous drop -> overflow=1, drop_cnt=1.
REQ-046 COMMIT_TRACE_TS_EN defined: events at cycles 3 and 7 after reset -> trace_ts 3 then 7; reset at cycle 5 with 2 entries queued -> count=0, trace_valid=0 next cycle.

Source files
------------

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: captures retired-instruction side effects (register
// writeback and data-memory load/store) into a circular first-word-fall-through
// FIFO for an external trace consumer. Events arriving while the FIFO is full
// and not draining are dropped and counted.
//
// Optional feature: define COMMIT_TRACE_TS_EN to add a free-running 32-bit
// cycle counter whose value is stored with every entry and presented on
// trace_ts. Without the macro there is no counter, no timestamp storage and
// no trace_ts port.
module commit_trace_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  input  logic                       trace_ready,
  input  logic                       overflow_clr,
  output logic                       trace_valid,
  output logic [2:0]                 trace_flags,
  output logic [4:0]                 trace_reg_num,
  output logic [DATA_W-1:0]          trace_reg_data,
  output logic [ADDR_W-1:0]          trace_addr,
  output logic [DATA_W-1:0]          trace_mem_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
`ifdef COMMIT_TRACE_TS_EN
  ,
  output logic [31:0]                trace_ts
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // One stored trace record; field order mirrors the trace_* outputs.
  typedef struct packed {
    logic              reg_we;
    logic              mem_wr;
    logic              mem_rd;
    logic [4:0]        reg_num;
    logic [DATA_W-1:0] reg_data;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_data;
`ifdef COMMIT_TRACE_TS_EN
    logic [31:0]       ts;
`endif
  } entry_t;

  // Storage is deliberately not reset; only pointers and count define validity.
  entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
`ifdef COMMIT_TRACE_TS_EN
  logic [31:0]      ts_q, ts_d;
`endif

  logic   reg_we_evt;
  logic   event_evt;
  logic   is_full;
  logic   is_empty;
  logic   pop_en;
  logic   push_en;
  logic   drop_en;
  entry_t entry_d;
  entry_t head;

  // Classify this cycle's activity and decide push, pop and drop.
  always_comb begin
    reg_we_evt = reg_write_sig && (reg_num != 5'd0);
    event_evt  = reg_we_evt || wr || rd;
    is_full    = (count_q == CNT_FULL);
    is_empty   = (count_q == '0);
    pop_en     = reset && !is_empty && trace_ready;
    push_en    = reset && event_evt && (!is_full || pop_en);
    drop_en    = reset && event_evt && is_full && !pop_en;
  end

  // Assemble the record that would be written this cycle.
  always_comb begin
    entry_d          = '0;
    entry_d.reg_we   = reg_we_evt;
    entry_d.mem_wr   = wr;
    entry_d.mem_rd   = rd;
    entry_d.reg_num  = reg_num;
    entry_d.reg_data = reg_data;
    entry_d.addr     = addr;
    entry_d.mem_data = wr ? wr_data : rd_data;
`ifdef COMMIT_TRACE_TS_EN
    entry_d.ts       = ts_q;
`endif
  end

  // Pointer, occupancy and overflow bookkeeping for the next edge.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, so the drop is never lost.
    if (drop_en) begin
      overflow_d = 1'b1;
      if (overflow_clr) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

`ifdef COMMIT_TRACE_TS_EN
  // Free-running cycle counter; wraps naturally at 32 bits.
  always_comb begin
    ts_d = ts_q + 32'd1;
  end
`endif

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef COMMIT_TRACE_TS_EN
  // Timestamp counter restarts from zero on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  // Entry storage write; push_en is already blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  // Present the head entry, forcing all fields to zero when nothing is queued.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    trace_valid    = !is_empty;
    trace_flags    = 3'b000;
    trace_reg_num  = 5'd0;
    trace_reg_data = '0;
    trace_addr     = '0;
    trace_mem_data = '0;
`ifdef COMMIT_TRACE_TS_EN
    trace_ts       = 32'd0;
`endif
    if (!is_empty) begin
      trace_flags    = {head.reg_we, head.mem_wr, head.mem_rd};
      trace_reg_num  = head.reg_num;
      trace_reg_data = head.reg_data;
      trace_addr     = head.addr;
      trace_mem_data = head.mem_data;
`ifdef COMMIT_TRACE_TS_EN
      trace_ts       = head.ts;
`endif
    end
  end

  // Status outputs come straight from the registers.
  always_comb begin
    count    = count_q;
    overflow = overflow_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: scoreboard bench for commit_trace_buf (DEPTH=16).
// Define COMMIT_TRACE_TS_EN for both bench and design to exercise timestamps.
module tb_commit_trace_buf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              reg_write_sig;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              trace_ready;
  logic              overflow_clr;
  logic              trace_valid;
  logic [2:0]        trace_flags;
  logic [4:0]        trace_reg_num;
  logic [DATA_W-1:0] trace_reg_data;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_mem_data;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [15:0]       drop_cnt;
`ifdef COMMIT_TRACE_TS_EN
  logic [31:0]       trace_ts;
`endif

  commit_trace_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write_sig  (reg_write_sig),
    .reg_num        (reg_num),
    .reg_data       (reg_data),
    .wr             (wr),
    .rd             (rd),
    .addr           (addr),
    .wr_data        (wr_data),
    .rd_data        (rd_data),
    .trace_ready    (trace_ready),
    .overflow_clr   (overflow_clr),
    .trace_valid    (trace_valid),
    .trace_flags    (trace_flags),
    .trace_reg_num  (trace_reg_num),
    .trace_reg_data (trace_reg_data),
    .trace_addr     (trace_addr),
    .trace_mem_data (trace_mem_data),
    .count          (count),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
`ifdef COMMIT_TRACE_TS_EN
    ,
    .trace_ts       (trace_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  flags;
    logic [4:0]  regNum;
    logic [31:0] regData;
    logic [8:0]  addr;
    logic [31:0] memData;
    logic [31:0] ts;
  } entry_t;

  entry_t      sbQueue[$];
  logic        modelOverflow;
  logic [15:0] modelDrop;
  logic [31:0] modelTs;
  int          checkCount = 0;
  int          passCount  = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Compare every DUT output against the scoreboard head and model status.
  task automatic compareOutputs();
    checkOutput("count", 64'(count), 64'(sbQueue.size()));
    checkOutput("trace_valid", 64'(trace_valid), 64'(sbQueue.size() != 0));
    checkOutput("overflow", 64'(overflow), 64'(modelOverflow));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(modelDrop));
    if (sbQueue.size() != 0) begin
      checkOutput("flags", 64'(trace_flags), 64'(sbQueue[0].flags));
      checkOutput("reg_num", 64'(trace_reg_num), 64'(sbQueue[0].regNum));
      checkOutput("reg_data", 64'(trace_reg_data), 64'(sbQueue[0].regData));
      checkOutput("addr", 64'(trace_addr), 64'(sbQueue[0].addr));
      checkOutput("mem_data", 64'(trace_mem_data), 64'(sbQueue[0].memData));
`ifdef COMMIT_TRACE_TS_EN
      checkOutput("trace_ts", 64'(trace_ts), 64'(sbQueue[0].ts));
`endif
    end else begin
      checkOutput("idle_zero",
                  64'({trace_flags, trace_reg_num, trace_reg_data[15:0], trace_addr}) |
                  64'({trace_mem_data, trace_reg_data[31:16]}), 64'd0);
`ifdef COMMIT_TRACE_TS_EN
      checkOutput("idle_ts", 64'(trace_ts), 64'd0);
`endif
    end
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic updateModel();
    logic   evt, pop, full, drop;
    entry_t e;
    if (!reset) begin
      sbQueue.delete();
      modelOverflow = 1'b0;
      modelDrop     = 16'd0;
      modelTs       = 32'd0;
    end else begin
      evt  = (reg_write_sig && reg_num != 5'd0) || wr || rd;
      pop  = (sbQueue.size() != 0) && trace_ready;
      full = (sbQueue.size() == DEPTH);
      drop = evt && full && !pop;
      if (pop) void'(sbQueue.pop_front());
      if (evt && (!full || pop)) begin
        e.flags   = {reg_write_sig && reg_num != 5'd0, wr, rd};
        e.regNum  = reg_num;
        e.regData = reg_data;
        e.addr    = addr;
        e.memData = wr ? wr_data : rd_data;
        e.ts      = modelTs;
        sbQueue.push_back(e);
      end
      if (drop) begin
        modelOverflow = 1'b1;
        modelDrop = overflow_clr ? 16'd1 : (modelDrop == 16'hFFFF ? modelDrop : modelDrop + 16'd1);
      end else if (overflow_clr) begin
        modelOverflow = 1'b0;
        modelDrop     = 16'd0;
      end
      modelTs = modelTs + 32'd1;
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then step past the edge.
  task automatic applyStimulus(input logic rws, input logic [4:0] rn, input logic [31:0] rdat,
                               input logic w, input logic r, input logic [8:0] a,
                               input logic [31:0] wd, input logic [31:0] rdd,
                               input logic ready, input logic clr);
    reg_write_sig = rws; reg_num = rn; reg_data = rdat;
    wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd;
    trace_ready = ready; overflow_clr = clr;
    @(negedge clk);
    compareOutputs();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, ready, 1'b0);
  endtask

  task automatic loadEvent(input logic [8:0] a, input logic [31:0] d, input logic ready);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, a, 32'd0, d, ready, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    reg_write_sig = 0; reg_num = 0; reg_data = 0; wr = 0; rd = 0; addr = 0;
    wr_data = 0; rd_data = 0; trace_ready = 0; overflow_clr = 0;
    sbQueue.delete(); modelOverflow = 0; modelDrop = 0; modelTs = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Capture in the very first cycle out of reset.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("first_valid", 64'(trace_valid), 64'd1);
    checkOutput("first_flags", 64'(trace_flags), 64'b100);
    checkOutput("first_data", 64'(trace_reg_data), 64'hDEADBEEF);
    checkOutput("first_count", 64'(count), 64'd1);
    idle(1'b1);

    // Writeback to x0 is not an event.
    applyStimulus(1'b1, 5'd0, 32'h11111111, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("x0_count", 64'(count), 64'd0);

    // Store plus writeback in one cycle yields a single combined entry.
    applyStimulus(1'b1, 5'd3, 32'hCAFE0003, 1'b1, 1'b0, 9'h1A4, 32'h12345678, 32'hBAD0BAD0, 1'b0, 1'b0);
    checkOutput("combo_count", 64'(count), 64'd1);
    checkOutput("combo_flags", 64'(trace_flags), 64'b110);
    checkOutput("combo_mem", 64'(trace_mem_data), 64'h12345678);
    idle(1'b1);

    // Twenty loads with no consumer: sixteen kept, four dropped.
    for (int i = 0; i < 20; i++) loadEvent(9'(i + 16), $urandom, 1'b0);
    checkOutput("fill_count", 64'(count), 64'd16);
    checkOutput("fill_ovf", 64'(overflow), 64'd1);
    checkOutput("fill_drop", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 16; i++) idle(1'b1);
    checkOutput("drain_valid", 64'(trace_valid), 64'd0);

    // Push while full and popping keeps count; clear with simultaneous drop.
    for (int i = 0; i < 16; i++) loadEvent(9'(i), $urandom, 1'b0);
    loadEvent(9'h0AA, 32'hA5A5A5A5, 1'b1);
    checkOutput("full_pp_count", 64'(count), 64'd16);
    checkOutput("full_pp_drop", 64'(drop_cnt), 64'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 9'h0BB, 32'd0, 32'h5A5A5A5A, 1'b0, 1'b1);
    checkOutput("clr_drop_ovf", 64'(overflow), 64'd1);
    checkOutput("clr_drop_cnt", 64'(drop_cnt), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("clr_ovf", 64'(overflow), 64'd0);

    // Random traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    9'($urandom), $urandom, $urandom,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 17; i++) idle(1'b1);

    // Events at cycles 3 and 7 after reset carry those timestamps.
    reset = 1'b0; idle(1'b0); reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3 || c == 7) loadEvent(9'(c), 32'(c), 1'b0);
      else idle(1'b0);
    end
    checkOutput("ts_count", 64'(count), 64'd2);
`ifdef COMMIT_TRACE_TS_EN
    checkOutput("ts_first", 64'(trace_ts), 64'd3);
    idle(1'b1);
    checkOutput("ts_second", 64'(trace_ts), 64'd7);
`endif

    // Reset at cycle 5 with two entries queued discards them and any event.
    reset = 1'b0; idle(1'b0); reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1 || c == 2) loadEvent(9'(c), 32'(c), 1'b0);
      else idle(1'b0);
    end
    reset = 1'b0;
    loadEvent(9'h1FF, 32'hFFFF0000, 1'b0);
    reset = 1'b1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_valid", 64'(trace_valid), 64'd0);
    idle(1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
